// File: rtl/vga_pkg.sv
// vga_pkg: shared VGA geometry, RGB332 field positions and pixel pipeline depth
package vga_pkg;
    localparam int H_RES    = 640;
    localparam int V_RES    = 480;
    localparam int FB_DEPTH = H_RES * V_RES;
    localparam int LAT      = 3;
    localparam int R_HI = 7, R_LO = 5;
    localparam int G_HI = 4, G_LO = 2;
    localparam int B_HI = 1, B_LO = 0;
endpackage

// File: rtl/vga_fb_dpram.sv
// vga_fb_dpram: two-bank simple dual-port RAM, bank in the address MSB, registered read
module vga_fb_dpram #(
    parameter int DEPTH = 307200,
    parameter int AW    = 19,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW:0]   wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    input  logic [AW:0]   rd_addr,
    output logic [DW-1:0] rd_data
);
    logic [DW-1:0] mem [2][DEPTH];
    always_ff @(posedge clk) begin
        if (we) mem[wr_addr[AW]][wr_addr[AW-1:0]] <= wr_data;
        if (rd_en) rd_data <= mem[rd_addr[AW]][rd_addr[AW-1:0]];
    end
endmodule

// File: rtl/vga_framebuffer_pixel_stage.sv
// vga_framebuffer_pixel_stage: double-buffered RGB332 framebuffer read pipeline with tear-free bank swap
module vga_framebuffer_pixel_stage import vga_pkg::*; #(
    parameter int FB_DEPTH = vga_pkg::FB_DEPTH,
    parameter int ADDR_W   = 19,
    parameter int PIX_W    = 8,
    parameter int LAT      = vga_pkg::LAT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pix_ce,
    input  logic              hsync_in,
    input  logic              vsync_in,
    input  logic              dena_in,
    input  logic [ADDR_W-1:0] fb_rd_addr,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [PIX_W-1:0]  wr_data,
    input  logic              swap_req,
    output logic              swap_ack,
    output logic              front_buf,
    output logic [7:0]        vga_r,
    output logic [7:0]        vga_g,
    output logic [7:0]        vga_b,
    output logic              vga_hs,
    output logic              vga_vs,
    output logic              vga_blank_n
);
    logic              swap_pending, boundary, do_swap, wr_en, s1_bank;
    logic [ADDR_W-1:0] s1_addr;
    logic [PIX_W-1:0]  rd_data;
    logic [LAT-1:0]    hs_sr, vs_sr, de_sr;
    logic [2:0]        r3, g3;
    logic [1:0]        b2;

    assign wr_ready = !swap_pending;
    assign wr_en    = wr_valid && wr_ready && (wr_addr < ADDR_W'(FB_DEPTH));
    // vs_sr[0] holds vsync_in as sampled on the previous pixel strobe
    assign boundary = pix_ce && vs_sr[0] && !vsync_in;
    assign do_swap  = boundary && (swap_pending || swap_req);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            swap_pending <= 1'b0;
            front_buf    <= 1'b0;
            swap_ack     <= 1'b0;
        end else begin
            swap_ack <= do_swap;
            if (do_swap) begin
                front_buf    <= !front_buf;
                swap_pending <= 1'b0;
            end else if (swap_req) begin
                swap_pending <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hs_sr   <= '1;
            vs_sr   <= '1;
            de_sr   <= '0;
            s1_addr <= '0;
            s1_bank <= 1'b0;
        end else if (pix_ce) begin
            hs_sr   <= {hs_sr[LAT-2:0], hsync_in};
            vs_sr   <= {vs_sr[LAT-2:0], vsync_in};
            de_sr   <= {de_sr[LAT-2:0], dena_in};
            s1_addr <= (fb_rd_addr < ADDR_W'(FB_DEPTH)) ? fb_rd_addr : '0;
            s1_bank <= front_buf;
        end
    end

    vga_fb_dpram #(.DEPTH(FB_DEPTH), .AW(ADDR_W), .DW(PIX_W)) u_ram (
        .clk     (clk),
        .we      (wr_en),
        .wr_addr ({!front_buf, wr_addr}),
        .wr_data (wr_data),
        .rd_en   (pix_ce),
        .rd_addr ({s1_bank, s1_addr}),
        .rd_data (rd_data)
    );

    assign r3 = rd_data[R_HI:R_LO];
    assign g3 = rd_data[G_HI:G_LO];
    assign b2 = rd_data[B_HI:B_LO];

    // de_sr[LAT-2] is the enable of the pixel whose RAM data is now in rd_data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vga_r <= '0;
            vga_g <= '0;
            vga_b <= '0;
        end else if (pix_ce) begin
            vga_r <= de_sr[LAT-2] ? {r3, r3, r3[2:1]} : '0;
            vga_g <= de_sr[LAT-2] ? {g3, g3, g3[2:1]} : '0;
            vga_b <= de_sr[LAT-2] ? {b2, b2, b2, b2} : '0;
        end
    end

    assign vga_hs      = hs_sr[LAT-1];
    assign vga_vs      = vs_sr[LAT-1];
    assign vga_blank_n = de_sr[LAT-1];
endmodule

// File: tb/tb_vga_framebuffer_pixel_stage.sv
// tb_vga_framebuffer_pixel_stage: directed and randomized checks against a behavioural pixel-stage model
module tb_vga_framebuffer_pixel_stage;
    localparam int FB  = 307200;
    localparam int LAT = 3;

    logic        clk = 1'b0, rst = 1'b1;
    logic        pix_ce = 1'b0, hsync_in = 1'b1, vsync_in = 1'b1, dena_in = 1'b0;
    logic [18:0] fb_rd_addr = '0, wr_addr = '0;
    logic        wr_valid = 1'b0, swap_req = 1'b0;
    logic [7:0]  wr_data = '0;
    logic        wr_ready, swap_ack, front_buf, vga_hs, vga_vs, vga_blank_n;
    logic [7:0]  vga_r, vga_g, vga_b;

    vga_framebuffer_pixel_stage dut (
        .clk(clk), .rst(rst), .pix_ce(pix_ce), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .dena_in(dena_in), .fb_rd_addr(fb_rd_addr), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_addr(wr_addr), .wr_data(wr_data), .swap_req(swap_req), .swap_ack(swap_ack),
        .front_buf(front_buf), .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_blank_n(vga_blank_n)
    );

    always #5 clk = !clk;

    int n_tests = 0, n_fail = 0;
    bit cmp_on = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [23:0] expand(input logic [7:0] p);
        int r, g, b;
        r = int'(p[7:5]);
        g = int'(p[4:2]);
        b = int'(p[1:0]);
        return {8'(r * 36 + r / 2), 8'(g * 36 + g / 2), 8'(b * 85)};
    endfunction

    typedef struct {
        bit          hs, vs, de, ok;
        logic [23:0] rgb;
        bit          bank;
        int          addr;
    } pix_t;

    pix_t        q[$];
    logic [7:0]  mem_m [2][64];
    bit          known [2][64];
    bit          front_m, pend_m, ack_m, vs_last;

    // Reference: one list entry per pixel strobe, output is the entry LAT strobes old
    always @(posedge clk or posedge rst) begin
        pix_t p;
        bit   bnd;
        int   a;
        if (rst) begin
            front_m = 0; pend_m = 0; ack_m = 0; vs_last = 1;
            q.delete();
            p = '{hs: 1, vs: 1, de: 0, ok: 1, rgb: 24'h0, bank: 0, addr: 0};
            repeat (LAT) q.push_back(p);
        end else begin
            bnd = pix_ce && vs_last && !vsync_in;
            if (pix_ce) begin
                a = (int'(fb_rd_addr) >= FB) ? 0 : int'(fb_rd_addr);
                p.hs = hsync_in; p.vs = vsync_in; p.de = dena_in;
                p.bank = front_m; p.addr = a;
                p.ok  = !dena_in || (a < 64 && known[front_m][a]);
                p.rgb = (dena_in && a < 64) ? expand(mem_m[front_m][a]) : 24'h0;
                q.push_back(p);
                void'(q.pop_front());
                vs_last = vsync_in;
            end
            if (wr_valid && !pend_m && int'(wr_addr) < 64) begin
                mem_m[!front_m][wr_addr] = wr_data;
                known[!front_m][wr_addr] = 1;
                foreach (q[i]) if (q[i].bank == !front_m && q[i].addr == int'(wr_addr)) q[i].ok = 0;
            end
            ack_m = bnd && (pend_m || swap_req);
            if (ack_m) begin
                front_m = !front_m;
                pend_m = 0;
            end else if (swap_req) begin
                pend_m = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && cmp_on) begin
            chk("hs", vga_hs, q[0].hs);
            chk("vs", vga_vs, q[0].vs);
            chk("blank_n", vga_blank_n, q[0].de);
            if (q[0].ok) chk("rgb", {vga_r, vga_g, vga_b}, q[0].rgb);
            chk("front_buf", front_buf, front_m);
            chk("swap_ack", swap_ack, ack_m);
            chk("wr_ready", wr_ready, !pend_m);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " rgb"}, {vga_r, vga_g, vga_b}, 24'h0);
        chk({tag, " syncs"}, {vga_hs, vga_vs}, 2'b11);
        chk({tag, " blank_n"}, vga_blank_n, 1'b0);
        chk({tag, " front/ack/ready"}, {front_buf, swap_ack, wr_ready}, 3'b001);
    endtask

    int pos = 0;

    initial begin
        repeat (3) cyc();
        rst = 1'b0;
        chk_reset_vals("reset");
        cmp_on = 1'b1;
        // Write and display
        wr_valid = 1; wr_addr = 0; wr_data = 8'hE0; cyc();
        wr_addr = 1; wr_data = 8'h1C; cyc();
        wr_valid = 0; swap_req = 1; cyc();
        swap_req = 0;
        chk("ready drops", wr_ready, 1'b0);
        wr_valid = 1; wr_addr = 0; wr_data = 8'hFF; cyc();
        wr_valid = 0;
        chk("ready held", {wr_ready, swap_ack}, 2'b00);
        pix_ce = 1; vsync_in = 0; cyc();
        chk("swap done", {swap_ack, front_buf, wr_ready}, 3'b111);
        vsync_in = 1; dena_in = 1; fb_rd_addr = 0; cyc();
        chk("ack one clk", swap_ack, 1'b0);
        fb_rd_addr = 1; cyc();
        chk("not early", {vga_r, vga_blank_n}, 9'h0);
        fb_rd_addr = 19'(FB); cyc();
        chk("pix0 red", {vga_r, vga_g, vga_b, 7'h0, vga_blank_n}, 32'hFF000001);
        dena_in = 0; fb_rd_addr = 1; cyc();
        chk("pix1 green", {vga_r, vga_g, vga_b}, 24'h00FF00);
        cyc();
        chk("oor read addr0", {vga_r, vga_g, vga_b}, 24'hFF0000);
        cyc();
        chk("blanked", {vga_r, vga_g, vga_b, 7'h0, vga_blank_n}, 32'h0);
        // Swap request landing on the boundary cycle
        vsync_in = 0; swap_req = 1; cyc();
        swap_req = 0;
        chk("same-cycle swap", {swap_ack, front_buf, wr_ready}, 3'b101);
        vsync_in = 1; cyc();
        swap_req = 1; cyc();
        swap_req = 0; cyc();
        swap_req = 1; cyc();
        swap_req = 0; vsync_in = 0; cyc();
        chk("double req swap", {swap_ack, front_buf}, 2'b11);
        vsync_in = 1; cyc();
        vsync_in = 0; cyc();
        chk("no second swap", {swap_ack, front_buf}, 2'b01);
        vsync_in = 1;
        wr_valid = 1; wr_addr = 19'(FB); wr_data = 8'h03; cyc();
        wr_valid = 0;
        chk("oor write ready", wr_ready, 1'b1);
        // Randomized frames
        for (int c = 0; c < 6000; c++) begin
            if (c == 3000) begin
                pix_ce = 0; wr_valid = 0; swap_req = 1; cyc();
                swap_req = 0;
                @(posedge clk);
                #3 rst = 1;
                #1 chk_reset_vals("async reset");
                repeat (3) cyc();
                chk_reset_vals("reset held");
                rst = 0;
            end
            pix_ce = $urandom_range(0, 3) != 0;
            if (pix_ce) begin
                vsync_in   = !(pos < 6);
                hsync_in   = !((pos % 25) < 3);
                dena_in    = (pos >= 12) && ((pos % 25) >= 5);
                fb_rd_addr = ($urandom_range(0, 9) == 0) ? 19'(FB + $urandom_range(0, 2)) : 19'($urandom_range(0, 63));
                pos = (pos + 1) % 150;
            end
            swap_req = $urandom_range(0, 199) == 0;
            wr_valid = $urandom_range(0, 1) == 1;
            wr_addr  = ($urandom_range(0, 9) == 0) ? ($urandom_range(0, 1) == 1 ? 19'h7FFFF : 19'(FB + $urandom_range(0, 15)))
                                                   : 19'($urandom_range(0, 63));
            wr_data  = 8'($urandom);
            cyc();
        end
        pix_ce = 0; wr_valid = 0; swap_req = 0;
        cyc();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
